cdb_arbiter: RTL and testbench

Shares the single result broadcast bus (CDB) among the execution units (ALU, branch unit, load/store buffer) that write results back to the reorder buffer and reservation stations. Each requester has a small private queue so a unit finishing while the bus is busy does not stall. A round-robin scheduler drains the queues onto a registered CDB at one result per cycle. A pipeline clear from the reorder buffer flushes every pending result.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/cdb_req_queue.sv | 54 +++++
 rtl/cdb_arbiter.sv | 91 +++++++++
 tb/tb_cdb_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core constants: ROB id / result widths and CDB requester indices.
package cpu_pkg;
  localparam int ROB_ID_W = 5;
  localparam int DATA_W   = 32;
  localparam int REQ_ALU  = 0;
  localparam int REQ_BR   = 1;
  localparam int REQ_LSB  = 2;
endpackage

// File: rtl/cdb_req_queue.sv
// Small per-requester result FIFO with synchronous flush; pointers wrap naturally.
module cdb_req_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok, pop_ok;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining per-unit result queues onto the registered CDB.
module cdb_arbiter #(
  parameter int N_REQ    = 3,
  parameter int ROB_ID_W = cpu_pkg::ROB_ID_W,
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int Q_DEPTH  = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        clear_in,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ROB_ID_W-1:0]   req_rob_id,
  input  logic [N_REQ*DATA_W-1:0]     req_value,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        cdb_valid,
  output logic [ROB_ID_W-1:0]         cdb_rob_id,
  output logic [DATA_W-1:0]           cdb_value,
  output logic [$clog2(N_REQ)-1:0]    cdb_src
);
  import cpu_pkg::*;

  localparam int SRC_W = $clog2(N_REQ);
  localparam int ENT_W = ROB_ID_W + DATA_W;

  logic [N_REQ-1:0] full, empty, push, pop;
  logic [ENT_W-1:0] head [N_REQ];
  logic             advance, flush, grant_any;
  logic [SRC_W-1:0] grant_idx, last_grant;
  int               cand;

  assign advance   = rdy_in && !clear_in;
  assign flush     = rdy_in && clear_in;
  // A full queue refuses input even while it is being drained this cycle.
  assign req_ready = ~full & {N_REQ{advance}};
  assign push      = req_valid & req_ready;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_q
    cdb_req_queue #(.DEPTH(Q_DEPTH), .WIDTH(ENT_W)) u_q (
      .clk       (clk_in),
      .rst_n     (rst_in),
      .push      (push[gi]),
      .pop       (pop[gi]),
      .flush     (flush),
      .push_data ({req_rob_id[gi*ROB_ID_W +: ROB_ID_W], req_value[gi*DATA_W +: DATA_W]}),
      .full      (full[gi]),
      .empty     (empty[gi]),
      .head_data (head[gi])
    );
  end

  // First non-empty queue at or after last_grant+1, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(last_grant) + 1 + k) % N_REQ;
      if (!grant_any && !empty[cand]) begin
        grant_any = 1'b1;
        grant_idx = SRC_W'(cand);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (advance && grant_any) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      cdb_src    <= '0;
      last_grant <= SRC_W'(N_REQ - 1);
    end else if (rdy_in) begin
      if (clear_in) begin
        cdb_valid <= 1'b0;
      end else if (grant_any) begin
        cdb_valid               <= 1'b1;
        {cdb_rob_id, cdb_value} <= head[grant_idx];
        cdb_src                 <= grant_idx;
        last_grant              <= grant_idx;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: per-source expected queues plus broadcast-order checks.
module tb_cdb_arbiter;
  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] val;
  } ent_t;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic [2:0]  req_valid;
  logic [14:0] req_rob_id;
  logic [95:0] req_value;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [4:0]  cdb_rob_id;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;

  cdb_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .req_valid(req_valid), .req_rob_id(req_rob_id), .req_value(req_value),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
    .cdb_value(cdb_value), .cdb_src(cdb_src)
  );

  always #5 clk_in = ~clk_in;

  int         total = 0;
  int         bad = 0;
  ent_t       src_q [3][$];
  ent_t       exp_q [3][$];
  logic [6:0] seen [$];
  logic [2:0] acc = '0;
  logic       cleared = 1'b0;
  logic       edge_rdy = 1'b0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t mk(int id, logic [31:0] v);
    ent_t e;
    e.id  = 5'(id);
    e.val = v;
    return e;
  endfunction

  function automatic ent_t mkd(int id);
    return mk(id, 32'hC0DE_0000 | 32'(id));
  endfunction

  // Edge-time bookkeeping: what was accepted, and whether a flush happened.
  always @(posedge clk_in) begin
    if (rst_in) begin
      edge_rdy = rdy_in;
      for (int i = 0; i < 3; i++) begin
        acc[i] = req_valid[i] && req_ready[i];
        if (acc[i]) exp_q[i].push_back(mk(int'(req_rob_id[i*5 +: 5]), req_value[i*32 +: 32]));
      end
      if (rdy_in && clear_in) begin
        cleared = 1'b1;
        for (int i = 0; i < 3; i++) exp_q[i].delete();
      end
    end else begin
      edge_rdy = 1'b0;
      acc      = '0;
    end
  end

  // Each fresh broadcast must match the head of its source's expected queue.
  always @(negedge clk_in) begin
    ent_t e;
    if (edge_rdy && cdb_valid) begin
      seen.push_back({cdb_src, cdb_rob_id});
      if (cdb_src < 2'd3 && exp_q[cdb_src].size() > 0) begin
        e = exp_q[cdb_src].pop_front();
        chk("cdb_rob_id", 64'(cdb_rob_id), 64'(e.id));
        chk("cdb_value", 64'(cdb_value), 64'(e.val));
      end else begin
        chk("cdb_expected_entry", 64'(exp_q[cdb_src].size() > 0), 64'd1);
      end
    end
  end

  task automatic drive_src();
    for (int i = 0; i < 3; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_rob_id[i*5 +: 5]  = src_q[i][0].id;
        req_value[i*32 +: 32] = src_q[i][0].val;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    for (int i = 0; i < 3; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (cleared)
      for (int i = 0; i < 3; i++) src_q[i].delete();
    acc     = '0;
    cleared = 1'b0;
    drive_src();
  endtask

  function automatic int pending();
    int n = int'(cdb_valid);
    for (int i = 0; i < 3; i++) n += src_q[i].size() + exp_q[i].size();
    return n;
  endfunction

  task automatic drain(string tag, int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      if (pending() == 0) break;
      tick();
    end
    chk(tag, 64'(pending()), 64'd0);
  endtask

  task automatic check_order(string tag, int ids[6], int n);
    chk({tag, "_count"}, 64'(seen.size()), 64'(n));
    for (int k = 0; k < n && k < seen.size(); k++)
      chk($sformatf("%s_%0d", tag, k), 64'(seen[k][4:0]), 64'(ids[k]));
  endtask

  initial begin
    int src2_ids[$];
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    req_valid = '0; req_rob_id = '0; req_value = '0;
    repeat (2) @(negedge clk_in);
    chk("rst_valid", 64'(cdb_valid), 0);
    chk("rst_rob_id", 64'(cdb_rob_id), 0);
    chk("rst_value", 64'(cdb_value), 0);
    chk("rst_src", 64'(cdb_src), 0);
    rst_in = 1'b1;
    #1 chk("rst_ready", 64'(req_ready), 64'h7);
    tick();

    // Simultaneous burst from reset priority, then again after a grant to 2.
    seen.delete();
    for (int i = 0; i < 3; i++) src_q[i].push_back(mkd(i + 1));
    drive_src();
    drain("rr1_drain", 10);
    check_order("rr1", '{1, 2, 3, 0, 0, 0}, 3);
    seen.delete();
    for (int i = 0; i < 3; i++) src_q[i].push_back(mkd(i + 4));
    drive_src();
    drain("rr2_drain", 10);
    check_order("rr2", '{4, 5, 6, 0, 0, 0}, 3);

    // Requester 2 fills its queue while 0 and 1 stay saturated.
    seen.delete();
    for (int k = 0; k < 6; k++) begin
      src_q[0].push_back(mkd(16 + k));
      src_q[1].push_back(mkd(22 + k));
    end
    src_q[2].push_back(mkd(7)); src_q[2].push_back(mkd(8)); src_q[2].push_back(mkd(9));
    drive_src();
    tick();
    chk("full_ready2_after1", 64'(req_ready[2]), 1);
    tick();
    chk("full_ready2_after2", 64'(req_ready[2]), 0);
    chk("full_src2_holds9", 64'(req_rob_id[14:10]), 9);
    drain("full_drain", 40);
    for (int k = 0; k < 6 && k < seen.size(); k++)
      chk($sformatf("full_rr_src_%0d", k), 64'(seen[k][6:5]), 64'(k % 3));
    src2_ids.delete();
    foreach (seen[k]) if (seen[k][6:5] == 2'd2) src2_ids.push_back(int'(seen[k][4:0]));
    chk("full_src2_count", 64'(src2_ids.size()), 3);
    for (int k = 0; k < 3 && k < src2_ids.size(); k++)
      chk($sformatf("full_src2_%0d", k), 64'(src2_ids[k]), 64'(7 + k));

    // Single result: one-cycle latency, one-cycle pulse, payload held.
    src_q[0].push_back(mk(5, 32'hDEAD_BEEF));
    drive_src();
    tick();
    chk("single_not_yet", 64'(cdb_valid), 0);
    tick();
    chk("single_valid", 64'(cdb_valid), 1);
    chk("single_rob_id", 64'(cdb_rob_id), 5);
    chk("single_value", 64'(cdb_value), 64'hDEAD_BEEF);
    chk("single_src", 64'(cdb_src), 0);
    tick();
    chk("single_pulse_end", 64'(cdb_valid), 0);
    chk("single_id_held", 64'(cdb_rob_id), 5);

    // Clear with a same-cycle push: nothing pending survives.
    seen.delete();
    src_q[1].push_back(mkd(10)); src_q[1].push_back(mkd(11));
    drive_src();
    tick();
    clear_in = 1'b1;
    src_q[0].push_back(mkd(12));
    drive_src();
    #1 chk("clear_ready", 64'(req_ready), 0);
    tick();
    clear_in = 1'b0;
    chk("clear_valid", 64'(cdb_valid), 0);
    drain("clear_drain", 10);
    chk("clear_no_bcast", 64'(seen.size()), 0);

    // Freeze with id 13 on the bus while another source is requesting.
    seen.delete();
    src_q[0].push_back(mkd(13)); src_q[0].push_back(mkd(14)); src_q[0].push_back(mkd(15));
    drive_src();
    tick();
    tick();
    chk("frz_pre_valid", 64'(cdb_valid), 1);
    chk("frz_pre_id", 64'(cdb_rob_id), 13);
    rdy_in = 1'b0;
    src_q[1].push_back(mkd(20));
    drive_src();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("frz_valid_%0d", c), 64'(cdb_valid), 1);
      chk($sformatf("frz_id_%0d", c), 64'(cdb_rob_id), 13);
      chk($sformatf("frz_ready_%0d", c), 64'(req_ready), 0);
    end
    rdy_in = 1'b1;
    drain("frz_drain", 20);
    check_order("frz", '{13, 14, 20, 15, 0, 0}, 4);

    // Asynchronous reset between edges in the middle of a burst.
    src_q[0].push_back(mkd(1)); src_q[0].push_back(mkd(2)); src_q[0].push_back(mkd(3));
    src_q[1].push_back(mkd(4)); src_q[1].push_back(mkd(5)); src_q[2].push_back(mkd(6));
    drive_src();
    tick();
    tick();
    chk("arst_pre_valid", 64'(cdb_valid), 1);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_valid", 64'(cdb_valid), 0);
    chk("arst_rob_id", 64'(cdb_rob_id), 0);
    chk("arst_value", 64'(cdb_value), 0);
    chk("arst_src", 64'(cdb_src), 0);
    for (int i = 0; i < 3; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    drive_src();
    @(negedge clk_in);
    rst_in = 1'b1;
    #1 chk("arst_ready", 64'(req_ready), 64'h7);
    seen.delete();
    src_q[1].push_back(mkd(30)); src_q[0].push_back(mkd(31));
    drive_src();
    drain("arst_drain", 10);
    check_order("arst_prio", '{31, 30, 0, 0, 0, 0}, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
